// File: rtl/cla_seq_adder_ctrl_if.sv
// Start/busy/done handshake and operand/result bus between the ALU datapath
// and the sequential carry-lookahead adder controller.
interface cla_seq_adder_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output start, a, b, sub, cin,
      input  busy, done, sum, cout, ovf, zero
   );

   modport slave (
      input  start, a, b, sub, cin,
      output busy, done, sum, cout, ovf, zero
   );
endinterface

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle adder/subtractor: one SLICE-bit carry-lookahead slice is reused
// for every slice of a WIDTH-bit operation, LSB first, carry held in a register.
module cla_seq_adder_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 4
) (
   input logic                 clk,
   input logic                 reset,
   cla_seq_adder_ctrl_if.slave bus
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic             carry_q;
   logic [KW-1:0]    k_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;
   logic             busy_q;
   logic             done_q;

   logic [SLICE-1:0] sa;
   logic [SLICE-1:0] sb;
   logic [SLICE-1:0] g;
   logic [SLICE-1:0] p;
   logic [SLICE-1:0] ssum;
   logic [SLICE:0]   c;
   logic             prop;
   logic [WIDTH-1:0] sum_nx;
   int unsigned      base;
   logic             last;
   logic             accept;

   assign accept = bus.start && (state_q != StRun);
   assign last   = (k_q == KW'(NSLICE - 1));

   // Flat sum-of-products lookahead: each carry is built from g/p and carry_q
   // directly, never from a lower carry of the same slice.
   always_comb begin
      base = 32'(k_q) * SLICE;
      sa   = opa_q[base +: SLICE];
      sb   = opb_q[base +: SLICE];
      g    = sa & sb;
      p    = sa ^ sb;
      prop = 1'b0;
      c    = '0;
      c[0] = carry_q;
      for (int i = 0; i < SLICE; i++) begin
         c[i+1] = g[i];
         prop   = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            c[i+1] = c[i+1] | (prop & g[j]);
            prop   = prop & p[j];
         end
         c[i+1] = c[i+1] | (prop & carry_q);
      end
      ssum                 = p ^ c[SLICE-1:0];
      sum_nx               = sum_q;
      sum_nx[base +: SLICE] = ssum;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         opa_q   <= '0;
         opb_q   <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (accept) begin
         // Subtraction becomes A + ~B + 1; cin only matters for add.
         opa_q   <= bus.a;
         opb_q   <= bus.sub ? ~bus.b : bus.b;
         carry_q <= bus.sub ? 1'b1 : bus.cin;
         k_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         state_q <= StRun;
      end else begin
         case (state_q)
            StRun: begin
               sum_q   <= sum_nx;
               carry_q <= c[SLICE];
               k_q     <= k_q + 1'b1;
               if (last) begin
                  cout_q  <= c[SLICE];
                  ovf_q   <= c[SLICE] ^ c[SLICE-1];
                  zero_q  <= (sum_nx == '0);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
   assign bus.zero = zero_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed bench for cla_seq_adder_ctrl: expected results are queued at start
// and compared when done pulses.
module tb_cla_seq_adder_ctrl;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned SLICE  = 4;
   localparam int unsigned NSLICE = WIDTH / SLICE;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   cla_seq_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

   cla_seq_adder_ctrl #(
      .WIDTH(WIDTH),
      .SLICE(SLICE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic cin);
      exp_t        e;
      logic [31:0] bb;
      logic [32:0] full;
      bb     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
      e.sum  = full[31:0];
      e.cout = full[32];
      e.ovf  = (a[31] == bb[31]) && (e.sum[31] != a[31]);
      e.zero = (e.sum == 32'd0);
      return e;
   endfunction

   function automatic logic [31:0] slice_mask(input int s);
      logic [63:0] m;
      m = (64'd1 << (s * SLICE)) - 64'd1;
      return m[31:0];
   endfunction

   task automatic launch(input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin);
      bus.a     = a;
      bus.b     = b;
      bus.sub   = sub;
      bus.cin   = cin;
      bus.start = 1'b1;
      sb_q.push_back(model(a, b, sub, cin));
   endtask

   // Called on the negedge where start was raised; returns on the done negedge.
   task automatic await_done(input string tag, input bit disturb);
      int   n;
      bit   seen;
      exp_t e;
      e    = sb_q[0];
      seen = 1'b0;
      @(negedge clk);
      n         = 1;
      bus.start = 1'b0;
      while (!seen && n <= 20) begin
         if (bus.done === 1'b1) begin
            seen = 1'b1;
         end else begin
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_partial"}, bus.sum, e.sum & slice_mask(n - 1));
            if (disturb && n == 3) begin
               bus.a     = ~bus.a;
               bus.b     = 32'h1357_9bdf;
               bus.sub   = ~bus.sub;
               bus.cin   = ~bus.cin;
               bus.start = 1'b1;
            end
            if (disturb && n == 4) bus.start = 1'b0;
            @(negedge clk);
            n++;
         end
      end
      e = sb_q.pop_front();
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(n), NSLICE + 1);
      check({tag, "_sum"}, bus.sum, e.sum);
      check({tag, "_cout"}, 32'(bus.cout), 32'(e.cout));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
      check({tag, "_zero"}, 32'(bus.zero), 32'(e.zero));
      check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_sum"}, bus.sum, 32'd0);
      check({tag, "_cout"}, 32'(bus.cout), 32'd0);
      check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
      check({tag, "_zero"}, 32'(bus.zero), 32'd0);
   endtask

   initial begin
      // Reset held two edges with start asserted.
      reset     = 1'b1;
      bus.start = 1'b1;
      bus.a     = 32'hffff_ffff;
      bus.b     = 32'h1;
      bus.sub   = 1'b0;
      bus.cin   = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_zero("reset");
      reset     = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      check("post_reset_busy", 32'(bus.busy), 32'd0);

      launch(32'hffff_ffff, 32'h0000_0001, 1'b0, 1'b0);
      await_done("add_wrap", 1'b0);
      @(negedge clk);
      check("add_wrap_pulse", 32'(bus.done), 32'd0);
      check("add_wrap_hold", bus.sum, 32'h0);

      launch(32'h7fff_ffff, 32'h0000_0001, 1'b0, 1'b0);
      await_done("add_ovf", 1'b0);
      launch(32'h1234_5678, 32'h0fed_cba8, 1'b0, 1'b1);
      await_done("add_cin", 1'b0);

      launch(32'd5, 32'd7, 1'b1, 1'b0);
      await_done("sub_neg", 1'b0);
      launch(32'd7, 32'd5, 1'b1, 1'b0);
      await_done("sub_pos", 1'b0);
      launch(32'h8000_0000, 32'd1, 1'b1, 1'b1);
      await_done("sub_ovf", 1'b0);

      // Operands and start disturbed mid-run, then start held into DONE.
      @(negedge clk);
      launch(32'hdead_beef, 32'h0bad_f00d, 1'b0, 1'b1);
      await_done("disturb", 1'b1);
      launch(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
      await_done("chain", 1'b0);

      // Reset in cycle 4 of a run aborts without a done pulse.
      launch(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_idle_zero("abort");
      begin
         int dones;
         dones = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
         end
         check("abort_no_done", 32'(dones), 32'd0);
      end
      void'(sb_q.pop_front());

      launch(32'h89ab_cdef, 32'h0123_4567, 1'b0, 1'b0);
      await_done("after_abort", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cla_seq_adder_ctrl.md
Name: cla_seq_adder_ctrl

Overview:
- Multi-cycle adder/subtractor controller that time-shares one SLICE-bit carry-lookahead slice across a WIDTH-bit operation, one slice per clock, LSB slice first.
- The ripple carry is held in a carry register between slices.
- Sits between the ALU datapath and the lookahead slice logic. Provides a start/busy/done handshake plus cout, signed-overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle by the lookahead slice.
- NSLICE, WIDTH/SLICE, derived; number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- sub  input  1  1 = A-B, 0 = A+B; sampled on the accepting edge.
- cin  input  1  carry-in for add; ignored when sub=1.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of the MSB (for sub: 1 = no borrow).
- ovf  output  1  signed overflow.
- zero  output  1  1 when sum == 0; valid with done and held afterwards.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. Reset=1 at an edge forces state IDLE and clears busy, done, sum, cout, ovf, zero, the slice index and the carry register to 0. This applies in every state, including mid-RUN; an aborted operation never asserts done.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → capture a into opA.
  - Capture b into opB, or ~b if sub=1.
  - Carry register ← (sub ? 1 : cin). Slice index k ← 0. sum ← 0. cout, ovf, zero ← 0.
  - Go to RUN.
- RUN:
  - Each cycle, process bits [k*SLICE+SLICE-1 : k*SLICE].
  - Per bit: g = a&b, p = a^b.
  - Per-bit carries come from lookahead over g/p and the carry register. No intra-slice ripple through sum bits.
  - Slice sum bits are written into sum at slice position k. Carry register ← slice carry-out. k ← k+1.
  - On slice k = NSLICE-1:
    - cout ← slice carry-out.
    - ovf ← carry into MSB XOR carry out of MSB.
    - zero ← (final sum == 0).
    - Go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE.
  - start=1 in the DONE cycle is accepted exactly as in IDLE: state goes directly to RUN, no IDLE cycle.
- busy: 1 exactly while state = RUN. start while busy=1 is ignored: no queuing, and operands are not re-sampled.
- Latency: start high in cycle 0 (accepted at the end of cycle 0) gives busy high in cycles 1..NSLICE and done high in cycle NSLICE+1.
  - Back-to-back throughput is one result per NSLICE+1 cycles.
- Output stability:
  - sum, cout, ovf, zero hold their values after done until the next accepted start.
  - During RUN, sum shows the slices completed so far; upper slices read 0.
- Arithmetic:
  - Modulo 2^WIDTH.
  - Subtraction is A + ~B + 1; cout=1 means A >= B unsigned.
  - ovf uses two's-complement semantics for both add and sub.
- a, b, sub and cin may change freely while busy; the result is unaffected.

Test Plan (WIDTH=32, SLICE=4, NSLICE=8):
1. Reset held 2 cycles with start=1 → busy=done=sum=cout=ovf=zero=0; no operation starts.
2. Add a=0xFFFFFFFF, b=0x00000001, cin=0, start pulse in cycle 0 → busy in cycles 1–8, done in cycle 9; sum=0x00000000, cout=1, zero=1, ovf=0.
3. Add a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, ovf=1, zero=0. Then add a=0x12345678, b=0x0FEDCBA8, cin=1 → sum=0x22222221, cout=0, ovf=0.
4. Sub a=5, b=7 → sum=0xFFFFFFFE, cout=0, ovf=0. Sub a=7, b=5, with cin=0 driven (must be ignored) → sum=0x00000002, cout=1. Sub a=0x80000000, b=1 → sum=0x7FFFFFFF, ovf=1.
5. Handshake:
   - Change a/b and pulse start in cycle 3 of a RUN → ignored; result matches the originally captured operands.
   - Start held high in the DONE cycle → new op accepted; busy high the next cycle; done exactly 9 cycles after the previous done.
6. Reset asserted in cycle 4 of a RUN → next cycle IDLE with all outputs 0; no done pulse. A fresh start afterwards completes normally with correct sum.
